// File: rtl/fetch_unit.sv
// fetch_unit
//   Holds the architectural fetch PC, issues in-order word-aligned fetch
//   requests to instruction memory, buffers returned instructions together
//   with their PC, and hands them to decode. Redirects flush the buffer and
//   discard responses that belong to the wrong path.
//
// Parameters
//   RESET_PC  fetch address loaded on reset
//   DEPTH     output buffer entries and in-flight request credit (pow2, >=2)
//
// Ports
//   clk, rst                         clock, async active-high reset
//   redirect_en, redirect_pc         taken branch/jump and its target
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order response channel, no backpressure
//   if_valid/ready                   decode handshake
//   if_instr, if_pc, if_pc_plus4     head instruction, its PC and PC+4
//   perf_fetched/stall/dropped       event counters (only with FETCH_PERF_EN)
//
// Build option
//   FETCH_PERF_EN  adds the three 32-bit performance counters.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_dropped
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]   LIMIT   = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc;

  // Tag FIFO: PC of each in-flight request, popped by responses in order.
  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_wp, tag_rp;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;

  // Output buffer toward decode.
  logic [31:0]   ob_pc    [DEPTH];
  logic [31:0]   ob_instr [DEPTH];
  logic [AW-1:0] ob_wp, ob_rp;
  logic [CW-1:0] occ;

  logic is_run, redir, req_fire, rsp_fire, rsp_drop, rsp_keep, if_fire;

  // Redirect targets are forced to word alignment; the low bits are discarded.
  logic redirect_lsb_unused;
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  assign is_run = (state == RUN);
  assign redir  = is_run & redirect_en;

  // Credit: requests in flight plus buffered entries never exceed DEPTH, so a
  // returning response always has a buffer slot.
  assign imem_req_valid = is_run & ~redirect_en &
                          (({1'b0, inflight} + {1'b0, occ}) < LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses in BOOT (or with nothing outstanding) are not ours.
  assign rsp_fire = is_run & imem_rsp_valid & (inflight != '0);
  // A response landing in the redirect cycle is already wrong-path.
  assign rsp_drop = rsp_fire & (redir | (drop_cnt != '0));
  assign rsp_keep = rsp_fire & ~rsp_drop;

  assign if_valid    = (occ != '0);
  assign if_fire     = if_valid & if_ready & ~redir;
  assign if_instr    = if_valid ? ob_instr[ob_rp]       : '0;
  assign if_pc       = if_valid ? ob_pc[ob_rp]          : '0;
  assign if_pc_plus4 = if_valid ? ob_pc[ob_rp] + 32'd4  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      tag_wp   <= '0;
      tag_rp   <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      if (redir)         fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire) fetch_pc <= fetch_pc + 32'd4;

      if (req_fire) tag_wp <= tag_wp + PTR_ONE;
      if (rsp_fire) tag_rp <= tag_rp + PTR_ONE;

      case ({req_fire, rsp_fire})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: ;
      endcase

      // Everything still outstanding after this cycle's pop is wrong-path.
      // No request can fire in a redirect cycle, so inflight is exact.
      if (redir)                         drop_cnt <= inflight - (rsp_fire ? CNT_ONE : '0);
      else if (rsp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob_wp <= '0;
      ob_rp <= '0;
      occ   <= '0;
    end else if (redir) begin
      ob_wp <= '0;
      ob_rp <= '0;
      occ   <= '0;
    end else begin
      if (rsp_keep) ob_wp <= ob_wp + PTR_ONE;
      if (if_fire)  ob_rp <= ob_rp + PTR_ONE;
      case ({rsp_keep, if_fire})
        2'b10:   occ <= occ + CNT_ONE;
        2'b01:   occ <= occ - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wp] <= fetch_pc;
    if (rsp_keep) begin
      ob_pc[ob_wp]    <= tag_mem[tag_rp];
      ob_instr[ob_wp] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_dropped <= '0;
    end else begin
      if (if_fire)                          perf_fetched <= perf_fetched + 32'd1;
      if (imem_req_valid & ~imem_req_ready) perf_stall   <= perf_stall + 32'd1;
      if (rsp_drop)                         perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Drives fetch_unit with a queued instruction-memory model (random, in-order
//   latency) and random decode/memory backpressure and redirects. Expected
//   results come from a stream model: the next request address and the next
//   delivered PC each advance by 4 and jump to the aligned target on redirect.
//   A second instance with RESET_PC = FFFF_FFF8 runs free to cover wrap-around.

module tb_fetch_unit;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  logic        w_redirect_en = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_req_valid;
  logic        w_req_ready   = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_if_valid;
  logic        w_if_ready    = 1'b1;
  logic [31:0] w_if_instr, w_if_pc, w_if_pc_plus4;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_dropped;
  logic [31:0] w_perf_fetched, w_perf_stall, w_perf_dropped;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_dropped(perf_dropped)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst),
    .redirect_en(w_redirect_en), .redirect_pc(w_redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .if_valid(w_if_valid), .if_ready(w_if_ready),
    .if_instr(w_if_instr), .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall), .perf_dropped(w_perf_dropped)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned rdy;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc, last_rdy, lat_lo, lat_hi;
  int          checks, errors;
  logic [31:0] req_exp, out_exp, w_exp, w_req_exp, w_pend_addr;
  bit          booting, release_pending, live_rsp, cur_stale, w_pend;
  int unsigned m_fetched;
`ifdef FETCH_PERF_EN
  int unsigned m_stall, m_dropped;
`endif

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic check_perf();
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_stall",   perf_stall,   m_stall);
    check("perf_dropped", perf_dropped, m_dropped);
  endtask
`endif

  // Decide what fires at the coming posedge from stable inputs/outputs.
  task automatic observe();
    logic [31:0] tgt;
    int unsigned r;
    check("credit", 32'((mq.size() + int'(live_rsp)) <= DEPTH), 32'd1);
    if (booting) check("boot_noreq", imem_req_valid, 32'd0);
    if (redirect_en && !booting) check("redir_noreq", imem_req_valid, 32'd0);

    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, req_exp);
      req_exp += 32'd4;
      r = cyc + $urandom_range(lat_hi, lat_lo);
      if (r < last_rdy) r = last_rdy;
      last_rdy = r;
      mq.push_back('{addr: imem_req_addr, rdy: r, stale: 1'b0});
    end
`ifdef FETCH_PERF_EN
    if (imem_req_valid && !imem_req_ready) m_stall++;
    if (live_rsp && (cur_stale || redirect_en)) m_dropped++;
`endif
    if (redirect_en && !booting) begin
      tgt = redirect_pc & 32'hFFFF_FFFC;
      req_exp = tgt;
      out_exp = tgt;
      foreach (mq[i]) mq[i].stale = 1'b1;
    end else if (if_valid && if_ready) begin
      check("if_pc",    if_pc,       out_exp);
      check("if_instr", if_instr,    mem_f(out_exp));
      check("if_pc4",   if_pc_plus4, out_exp + 32'd4);
      out_exp += 32'd4;
      m_fetched++;
    end

    if (w_req_valid) begin
      check("w_req_addr", w_req_addr, w_req_exp);
      w_req_exp += 32'd4;
    end
    if (w_if_valid) begin
      check("w_if_pc",    w_if_pc,       w_exp);
      check("w_if_instr", w_if_instr,    mem_f(w_exp));
      check("w_if_pc4",   w_if_pc_plus4, w_exp + 32'd4);
      if (w_exp == 32'hFFFF_FFFC) check("wrap_pc4", w_if_pc_plus4, 32'h0);
      w_exp += 32'd4;
    end
    w_pend      = w_req_valid;
    w_pend_addr = w_req_addr;
    booting     = 1'b0;
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit ifr, input bit mrdy);
    @(posedge clk);
    #1;
    cyc++;
    if (release_pending) begin
      rst = 1'b0;
      release_pending = 1'b0;
      booting = 1'b1;
    end
    redirect_en    = redir;
    redirect_pc    = rpc;
    if_ready       = ifr;
    imem_req_ready = mrdy;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    live_rsp       = 1'b0;
    cur_stale      = 1'b0;
    if (booting) begin
      // stray response while booting must be ignored
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (mq.size() > 0 && mq[0].rdy <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(mq[0].addr);
      cur_stale      = mq[0].stale;
      live_rsp       = 1'b1;
      void'(mq.pop_front());
    end
    w_rsp_valid = w_pend;
    w_rsp_data  = mem_f(w_pend_addr);
    @(negedge clk);
    observe();
  endtask

  task automatic do_reset(input int unsigned hold);
    rst = 1'b1;
    #1;
    check("rst_if_valid", if_valid,       32'd0);
    check("rst_req_valid", imem_req_valid, 32'd0);
    check("rst_req_addr", imem_req_addr,  32'h0);
    check("rst_if_instr", if_instr,       32'h0);
    check("rst_if_pc",    if_pc,          32'h0);
    check("rst_if_pc4",   if_pc_plus4,    32'h0);
    check("rst_w_addr",   w_req_addr,     32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
    check("rst_perf_f", perf_fetched, 32'h0);
    check("rst_perf_s", perf_stall,   32'h0);
    check("rst_perf_d", perf_dropped, 32'h0);
`endif
    mq.delete();
    last_rdy = 0;
    req_exp = 32'h0; out_exp = 32'h0;
    w_exp = 32'hFFFF_FFF8; w_req_exp = 32'hFFFF_FFF8;
    w_pend = 1'b0; w_pend_addr = '0;
    imem_rsp_valid = 1'b0; w_rsp_valid = 1'b0;
    redirect_en = 1'b0;
    m_fetched = 0;
`ifdef FETCH_PERF_EN
    m_stall = 0; m_dropped = 0;
`endif
    repeat (hold) @(posedge clk);
    release_pending = 1'b1;
  endtask

  task automatic boot_latency(input bit redir_in_boot);
    step(redir_in_boot, 32'h0000_0500, 1'b1, 1'b1);
    check("lat_c1", if_valid, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("lat_c2", if_valid, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("lat_c3", if_valid, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    check("lat_c4", if_valid, 32'd1);
    check("first_pc", if_pc, 32'h0);
  endtask

  initial begin
    bit done;
    logic [31:0] rpc;
    rst = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = 1'b1; w_rsp_valid = 1'b0; w_rsp_data = '0;
    checks = 0; errors = 0; cyc = 0; booting = 0; release_pending = 0;
    live_rsp = 0; cur_stale = 0; lat_lo = 1; lat_hi = 1;
    #3;

    // Reset, 1-cycle memory, decode always ready
    do_reset(2);
    boot_latency(1'b0);
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Decode backpressure fills the buffer, requests stop, then resume
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
    check("bp_if_valid", if_valid, 32'd1);
    check("bp_req_valid", imem_req_valid, 32'd0);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect with two requests in flight
    lat_lo = 4; lat_hi = 4;
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (mq.size() == 2 && !live_rsp) done = 1;
    end
    check("two_inflight_reached", 32'(done), 32'd1);
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    check("redir_cycle_noreq", imem_req_valid, 32'd0);
    done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (if_valid) begin
        check("redir_first_pc", if_pc, 32'h0000_0100);
        done = 1;
      end
    end
    check("redir_delivery", 32'(done), 32'd1);
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1);
`ifdef FETCH_PERF_EN
    check_perf();
`endif

    // Misaligned redirect target
    step(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1);
      if (imem_req_valid) begin
        check("misalign_addr", imem_req_addr, 32'h0000_0100);
        done = 1;
      end
    end
    check("misalign_req_seen", 32'(done), 32'd1);

    // Random traffic
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0))) : $urandom;
      step($urandom_range(15, 0) == 0, rpc, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    end
    check("progress", 32'(m_fetched >= 200), 32'd1);
`ifdef FETCH_PERF_EN
    check_perf();
`endif

    // Reset mid-stream with the buffer full; redirect during BOOT is ignored
    lat_lo = 1; lat_hi = 1;
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);
    check("pre_rst_if_valid", if_valid, 32'd1);
    do_reset(2);
    boot_latency(1'b1);
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1);
`ifdef FETCH_PERF_EN
    check_perf();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumer side of the next-PC path: holds the architectural fetch PC and accepts redirect targets from the branch/jump selection logic.
- Issues in-order fetch requests to instruction memory over a valid/ready interface.
- Buffers returned instructions with their PC and PC+4, and presents them to decode over a valid/ready handshake.
- Discards wrong-path responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 2, output buffer entries. Power of two, ≥2. This is also the credit limit on in-flight requests.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_en  in  1  taken branch/jump this cycle
- redirect_pc  in  32  redirect target (branch/jump target address)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, word aligned
- imem_rsp_valid  in  1  response valid, in order, no backpressure
- imem_rsp_data  in  32  fetched instruction
- if_valid  out  1  instruction available to decode
- if_ready  in  1  decode accepts instruction
- if_instr  out  32  instruction
- if_pc  out  32  PC of if_instr
- if_pc_plus4  out  32  if_pc + 4, mod 2^32

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; state = BOOT.
  - Output buffer empty; inflight = 0; drop = 0.
  - imem_req_valid = 0, if_valid = 0, imem_req_addr = RESET_PC, if_instr/if_pc/if_pc_plus4 = 0.
- FSM:
  - BOOT: one cycle after reset release; no requests; imem_rsp_valid ignored. Next state: RUN.
  - RUN: normal operation. No other states.
- Credit rule:
  - imem_req_valid = RUN & !redirect_en & (inflight + occupancy < DEPTH).
  - imem_req_addr = fetch_pc, combinationally.
- Request handshake (valid & ready): fetch_pc <= fetch_pc + 4 and inflight increments. PC is pushed into an internal DEPTH-entry tag FIFO.
- Response: pops the tag FIFO and decrements inflight.
  - If drop > 0: response discarded, drop decrements.
  - Otherwise: {tag pc, data, pc+4} pushed to the output buffer. Push never overflows, guaranteed by the credit rule.
- Output handshake:
  - if_valid = buffer not empty; head entry drives if_instr, if_pc and if_pc_plus4.
  - Pop on if_valid & if_ready.
  - A response arriving into an empty buffer is visible the next cycle (1-cycle rsp->if latency).
  - Simultaneous push and pop is allowed at any occupancy.
- Redirect (redirect_en = 1, RUN):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently cleared.
  - Output buffer flushed; an if handshake in the same cycle is ignored.
  - drop <= inflight after this cycle's rsp pop, so a response arriving in the redirect cycle is itself discarded. Tag FIFO entries are kept so later wrong-path pops still happen.
  - No request in the redirect cycle. The next cycle requests the target. New responses are accepted only once drop reaches 0.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0; if_pc_plus4 wraps identically.
- Reset mid-operation: all state cleared immediately. Instruction memory must also be reset; responses during BOOT are ignored.
- redirect_en during BOOT: ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds output perf_fetched (32): increments on each if handshake.
  - Adds output perf_stall (32): increments each RUN cycle with imem_req_valid & !imem_req_ready.
  - Adds output perf_dropped (32): increments per discarded response.
  - All three reset to 0 and wrap at 2^32.
- When undefined: these ports and their counters do not exist, and the behaviour above is otherwise unchanged.

Test Plan:
- Reset, memory always ready with 1-cycle latency, if_ready = 1, RESET_PC = 0: requests 0x0, 0x4, 0x8... Decode receives matching if_pc, with if_pc_plus4 = if_pc + 4. First if_valid appears 3 cycles after reset release.
- if_ready held low for 10 cycles: at most DEPTH (2) entries buffered plus in-flight within credit. imem_req_valid drops once the limit is reached. After if_ready = 1, delivery resumes in order with no loss and no duplicates.
- Redirect to 0x100 while 2 requests (0x8, 0xC) are in flight: both responses discarded. Next if_pc = 0x100, then 0x104. No request is issued in the redirect cycle.
- Redirect to 0x103: request address 0x100, if_pc = 0x100.
- RESET_PC = 32'hFFFF_FFF8: fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. if_pc_plus4 of FFFF_FFFC is 0.
- rst asserted mid-stream with 2 entries buffered: if_valid and imem_req_valid drop immediately. After release, the fetch sequence restarts at RESET_PC. With FETCH_PERF_EN, all counters read 0.
